store_buffer: RTL
=================

# store_buffer

Posted-write buffer that sits directly upstream of the data memory, between the core's load/store path and the memory's single address port. Stores are queued in a small circular FIFO and drained into memory one per cycle whenever the core is not using the port for a load. Loads read memory combinationally, with forwarding from any matching pending store. This keeps store traffic off the load path and gives the core a stall signal (`st_ready`) when the queue is full.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `ADDR_W`, 32: address width; word address, used directly as the memory index.
- `DATA_W`, 32: data width.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all buffer state.
- `st_valid`  in  1  core presents a store this cycle.
- `st_addr`  in  ADDR_W  store address.
- `st_data`  in  DATA_W  store data.
- `st_ready`  out  1  buffer can accept a store (count < DEPTH).
- `ld_valid`  in  1  core performs a load this cycle.
- `ld_addr`  in  ADDR_W  load address.
- `ld_data`  out  DATA_W  load result (forwarded or memory).
- `mem_addr`  out  ADDR_W  to data memory address port.
- `mem_w_data`  out  DATA_W  to data memory write data.
- `mem_write_en`  out  1  to data memory write enable.
- `mem_r_data`  in  DATA_W  from data memory read data.
- `count`  out  clog2(DEPTH)+1  occupied entries.
- `empty`  out  1  count == 0.

## Operation
- Storage: DEPTH entries of {addr, data}, plus head (oldest), tail (next free), and count. Pointers wrap modulo DEPTH.
- Push: occurs when `st_valid && st_ready` at an edge. Entry written at tail; tail+1.
- `st_valid` while full (`st_ready`=0) is ignored; the core must stall. `st_ready` is derived from count only; there is no same-cycle pass-through when a pop frees a slot.
- Port arbitration (combinational):
  - `ld_valid`=1: `mem_addr`=`ld_addr`, `mem_write_en`=0. The load has priority.
  - else if !empty: `mem_addr`=head.addr, `mem_w_data`=head.data, `mem_write_en`=1, and head pops at the edge.
  - else: `mem_addr`=`ld_addr`, `mem_write_en`=0.
- `mem_w_data` = head.data whenever not empty, else 0.
- Forwarding: compare `ld_addr` (full ADDR_W) against all occupied entries.
  - On one or more hits, `ld_data` = data of the youngest hit.
  - With no hit, `ld_data` = `mem_r_data`.
  - Non-occupied entries never match.
- Simultaneous push and pop: count unchanged; both pointers advance.
- A store pushed this cycle is not visible to a load in the same cycle. It becomes forwardable from the next cycle.
- Drain order is strict FIFO, so repeated stores to one address land in program order.

## Timing
- Reset values: count=0, head=tail=0, empty=1, st_ready=1, mem_write_en=0, mem_w_data=0. Entry contents are don't-care but unmatched.
- `reset` is asynchronous and effective immediately. Asserting it mid-operation discards all pending stores; no partial write is issued after assertion.
- Store-to-memory latency is 1 cycle minimum: a store pushed at edge N drives `mem_write_en` during cycle N→N+1, and memory captures it at edge N+1 (if no `ld_valid` and it is at head).
- Each cycle with `ld_valid`=1 delays draining by one cycle.
- `ld_data` is purely combinational from `ld_addr`, buffer state and `mem_r_data`, with zero cycle latency.
- `count` and `empty` are registered or derived from registered state; there is no combinational path from `st_valid` or `ld_valid`.

## Test plan
- Reset: pulse `reset` asynchronously mid-cycle -> immediately count=0, empty=1, st_ready=1, mem_write_en=0.
- Single store: addr 5, data 0xDEADBEEF, `ld_valid`=0 -> next cycle mem_write_en=1, mem_addr=5, mem_w_data=0xDEADBEEF; following cycle empty=1, and memory word 5 reads 0xDEADBEEF.
- Fill under loads: hold `ld_valid`=1 and push stores to addrs 0..3 -> st_ready=0 and count=4 after the 4th push, mem_write_en=0 throughout. A 5th store (addr 9) is ignored. Drop `ld_valid` -> writes appear in order 0,1,2,3 over 4 cycles.
- Forwarding: with the drain blocked by `ld_valid`, push addr 7 data 0x11 then addr 7 data 0x22. Load addr 7 -> ld_data=0x22. Load addr 8 -> ld_data=mem_r_data.
- Simultaneous push/pop and wrap: with count=2 and no loads, push every cycle for 6 cycles -> count stays 2, drained addresses match push order exactly, and head/tail wrap past DEPTH-1 with no loss.
- Reset mid-drain: 3 stores pending, assert `reset` -> count=0 and mem_write_en=0 at once. After release no further writes occur, and memory holds only stores drained before reset.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write FIFO in front of the data memory: stores drain one per cycle
// when the memory port is free of loads, and loads forward from pending stores.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     st_valid,
   input  logic [ADDR_W-1:0]        st_addr,
   input  logic [DATA_W-1:0]        st_data,
   output logic                     st_ready,
   input  logic                     ld_valid,
   input  logic [ADDR_W-1:0]        ld_addr,
   output logic [DATA_W-1:0]        ld_data,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_w_data,
   output logic                     mem_write_en,
   input  logic [DATA_W-1:0]        mem_r_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addr_r [DEPTH];
   logic [DATA_W-1:0] data_r [DEPTH];
   logic [PTR_W-1:0]  head_r;
   logic [PTR_W-1:0]  tail_r;
   logic [CNT_W-1:0]  count_r;

   logic              empty_s;
   logic              full_s;
   logic              push_s;
   logic              pop_s;
   logic              fwd_hit_s;
   logic [DATA_W-1:0] fwd_data_s;
   logic [PTR_W-1:0]  fwd_idx_s;

   assign empty_s  = (count_r == CNT_W'(0));
   assign full_s   = (count_r == CNT_W'(DEPTH));
   // A load owns the port for the whole cycle, so draining waits for a load-free cycle.
   assign push_s   = st_valid && !full_s;
   assign pop_s    = !ld_valid && !empty_s;

   assign st_ready = !full_s;
   assign count    = count_r;
   assign empty    = empty_s;

   // Head/tail pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_r  <= PTR_W'(0);
         tail_r  <= PTR_W'(0);
         count_r <= CNT_W'(0);
      end else begin
         if (push_s) begin
            tail_r <= tail_r + PTR_W'(1);
         end
         if (pop_s) begin
            head_r <= head_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry payload; validity comes from head/count, so contents need no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         addr_r[tail_r] <= st_addr;
         data_r[tail_r] <= st_data;
      end
   end

   // Forwarding: walk oldest to youngest so the youngest occupied hit wins.
   always_comb begin
      fwd_hit_s  = 1'b0;
      fwd_data_s = {DATA_W{1'b0}};
      fwd_idx_s  = head_r;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx_s = head_r + PTR_W'(k);
         if ((CNT_W'(k) < count_r) && (addr_r[fwd_idx_s] == ld_addr)) begin
            fwd_hit_s  = 1'b1;
            fwd_data_s = data_r[fwd_idx_s];
         end else begin
            fwd_hit_s  = fwd_hit_s;
            fwd_data_s = fwd_data_s;
         end
      end
   end

   // Load result: forwarded data overrides the memory read.
   always_comb begin
      if (fwd_hit_s) begin
         ld_data = fwd_data_s;
      end else begin
         ld_data = mem_r_data;
      end
   end

   // Memory port arbitration between the load and the head-of-queue drain.
   always_comb begin
      mem_addr     = ld_addr;
      mem_write_en = 1'b0;
      mem_w_data   = {DATA_W{1'b0}};
      if (pop_s) begin
         mem_addr     = addr_r[head_r];
         mem_write_en = 1'b1;
      end else begin
         mem_addr     = ld_addr;
         mem_write_en = 1'b0;
      end
      if (empty_s) begin
         mem_w_data = {DATA_W{1'b0}};
      end else begin
         mem_w_data = data_r[head_r];
      end
   end

endmodule
